mem_scheduler: RTL and testbench

Round-robin scheduler that shares one single-port synchronous memory (BSRAM-style, fixed read latency) between NUM_REQ requesters. Each requester issues one read or write at a time through a req/ack handshake. The scheduler owns the memory control signals, sequences issue/wait/complete, and returns read data. It sits between the client cores and the shared memory block and replaces ad-hoc per-client muxing.

---
 rtl/mem_scheduler.sv | 130 +++++++++++++
 tb/tb_mem_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_scheduler.sv
// mem_scheduler: round-robin arbiter that shares one single-port synchronous
// memory (fixed read latency) between NUM_REQ requesters.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req/we              per-requester request and write flag
//   addr/wdata          packed per-requester address / write data
//   ack                 one-cycle completion pulse to the owning requester
//   rdata               data of the last completed read (shared)
//   grant               one-hot current owner, 0 when idle
//   busy                high whenever the FSM is not IDLE
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobes, non-zero only in ISSUE
//   mem_rdata           memory read data, valid READ_LATENCY cycles after strobe
module mem_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]            ack,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   input  logic [DATA_WIDTH-1:0]         mem_rdata
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t                              state;
   logic [IW-1:0]                       ptr;     // last granted, doubles as owner index
   logic [CW-1:0]                       cnt;
   logic [IW-1:0]                       winner;
   logic                                found;
   logic [IW:0]                         sum;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_a;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  wdata_a;

   assign addr_a  = addr;
   assign wdata_a = wdata;
   assign busy    = (state != IDLE);

   // Search starts one past the last winner and wraps; the extra sum bit
   // keeps ptr+k from overflowing before the modulo fold.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(NUM_REQ))
            sum = sum - (IW+1)'(NUM_REQ);
         if (!found && req[sum[IW-1:0]]) begin
            winner = sum[IW-1:0];
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= IW'(NUM_REQ - 1);
         cnt       <= '0;
         ack       <= '0;
         grant     <= '0;
         rdata     <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Memory strobes are registered here so they appear in ISSUE.
               if (found) begin
                  state     <= ISSUE;
                  ptr       <= winner;
                  grant     <= NUM_REQ'(1) << winner;
                  mem_en    <= 1'b1;
                  mem_we    <= we[winner];
                  mem_addr  <= addr_a[winner];
                  mem_wdata <= wdata_a[winner];
               end
            end
            ISSUE: begin
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               if (mem_we) begin
                  state <= ACK;
                  ack   <= grant;
               end else begin
                  state <= WAIT;
                  cnt   <= CW'(READ_LATENCY);
               end
            end
            WAIT: begin
               cnt <= cnt - CW'(1);
               // cnt==1 marks the cycle READ_LATENCY after the strobe.
               if (cnt == CW'(1)) begin
                  rdata <= mem_rdata;
                  state <= ACK;
                  ack   <= grant;
               end
            end
            ACK: begin
               ack   <= '0;
               grant <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_scheduler.sv
module tb_mem_scheduler;

   logic              clk;
   logic              reset;
   logic [3:0]        req, we;
   logic [3:0][7:0]   addr;
   logic [3:0][31:0]  wdata;
   logic [3:0]        ack, grant;
   logic [31:0]       rdata, mem_wdata, mem_rdata;
   logic              busy, mem_en, mem_we;
   logic [7:0]        mem_addr;

   logic [3:0]        req2, we2;
   logic [3:0][7:0]   addr2;
   logic [3:0][31:0]  wdata2;
   logic [3:0]        ack2, grant2;
   logic [31:0]       rdata2, mwd2, mrd2;
   logic              busy2, men2, mwe2;
   logic [7:0]        maddr2;

   int total = 0;
   int bad   = 0;

   mem_scheduler #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   mem_scheduler #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
      .ack(ack2), .rdata(rdata2), .grant(grant2), .busy(busy2),
      .mem_en(men2), .mem_we(mwe2), .mem_addr(maddr2),
      .mem_wdata(mwd2), .mem_rdata(mrd2));

   always #5 clk = ~clk;

   // Latency-1 memory model; a write also drives its data onto mem_rdata so
   // that a scheduler wrongly capturing on writes is exposed.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (reset) mem_rdata <= 32'h0;
      else if (mem_en) begin
         if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            mem_rdata     <= mem_wdata;
         end else
            mem_rdata <= mem[mem_addr];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      total++; if ({ack, grant, busy, mem_en, mem_we} !== 11'b0) begin bad++; $display("FAIL rst_ctrl got ack=%b grant=%b busy=%b en=%b we=%b want all 0", ack, grant, busy, mem_en, mem_we); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got %h want 0", rdata); end
      total++; if (mem_addr !== 8'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem got addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
      total++; if ({ack2, grant2, busy2, men2} !== 10'b0 || rdata2 !== 32'h0) begin bad++; $display("FAIL rst_dut3 got ack=%b grant=%b busy=%b en=%b rdata=%h want 0", ack2, grant2, busy2, men2, rdata2); end
      reset = 1'b0;
      step();
      total++; if (busy !== 1'b0 || grant !== 4'b0) begin bad++; $display("FAIL rst_idle got busy=%b grant=%b want 0", busy, grant); end
   endtask

   task automatic test_write();
      req = 4'b0100; we = 4'b0100; addr[2] = 8'h10; wdata[2] = 32'hDEADBEEF;
      step(); // cycle 1: ISSUE
      total++; if ({mem_en, mem_we} !== 2'b11) begin bad++; $display("FAIL wr_strobe got en=%b we=%b want 1 1", mem_en, mem_we); end
      total++; if (mem_addr !== 8'h10 || mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_bus got addr=%h data=%h want 10 deadbeef", mem_addr, mem_wdata); end
      total++; if (grant !== 4'b0100 || ack !== 4'b0 || busy !== 1'b1) begin bad++; $display("FAIL wr_issue got grant=%b ack=%b busy=%b want 0100 0000 1", grant, ack, busy); end
      step(); // cycle 2: ACK
      total++; if (ack !== 4'b0100 || grant !== 4'b0100 || mem_en !== 1'b0) begin bad++; $display("FAIL wr_ack got ack=%b grant=%b en=%b want 0100 0100 0", ack, grant, mem_en); end
      req = 4'b0;
      step(); // cycle 3: IDLE
      total++; if (ack !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL wr_done got ack=%b grant=%b busy=%b want 0", ack, grant, busy); end
   endtask

   task automatic test_read_hold();
      req = 4'b0001; we = 4'b0000; addr[0] = 8'h10;
      step(); // cycle 1
      total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10 || grant !== 4'b0001) begin bad++; $display("FAIL rd_issue got en=%b we=%b addr=%h grant=%b want 1 0 10 0001", mem_en, mem_we, mem_addr, grant); end
      step(); // cycle 2: WAIT
      total++; if (ack !== 4'b0 || busy !== 1'b1 || mem_en !== 1'b0) begin bad++; $display("FAIL rd_wait got ack=%b busy=%b en=%b want 0 1 0", ack, busy, mem_en); end
      step(); // cycle 3: ACK
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL rd_ack got %b want 0001", ack); end
      total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got %h want deadbeef", rdata); end
      req = 4'b0;
      step();
      // write by requester 3 must leave rdata untouched
      req = 4'b1000; we = 4'b1000; addr[3] = 8'h20; wdata[3] = 32'h12345678;
      step();
      step();
      total++; if (ack !== 4'b1000) begin bad++; $display("FAIL hold_wack got %b want 1000", ack); end
      req = 4'b0;
      step();
      total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL hold_rdata got %h want deadbeef", rdata); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp;
      reset = 1'b1;
      step();
      reset = 1'b0;
      req = 4'b1111; we = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         addr[i]  = 8'h40 + 8'(i);
         wdata[i] = 32'h100 + 32'(i);
      end
      for (int n = 0; n < 8; n++) begin
         int w;
         exp = 4'b0001 << (n % 4);
         w = 0;
         do begin
            step();
            w++;
         end while (ack === 4'b0 && w < 8);
         total++; if (ack !== exp) begin bad++; $display("FAIL rr_ack n=%0d got %b want %b", n, ack, exp); end
         total++; if (grant !== exp) begin bad++; $display("FAIL rr_grant n=%0d got %b want %b", n, grant, exp); end
         step();
         total++; if (busy !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL rr_dead n=%0d got busy=%b ack=%b want 0 0", n, busy, ack); end
      end
      req = 4'b0;
      step();
   endtask

   task automatic test_latency3();
      req2 = 4'b0010; we2 = 4'b0000; addr2[1] = 8'h33; mrd2 = 32'h0BAD0001;
      step(); // cycle 1
      total++; if (men2 !== 1'b1 || mwe2 !== 1'b0 || maddr2 !== 8'h33 || grant2 !== 4'b0010) begin bad++; $display("FAIL l3_issue got en=%b we=%b addr=%h grant=%b want 1 0 33 0010", men2, mwe2, maddr2, grant2); end
      step(); // cycle 2
      total++; if (ack2 !== 4'b0 || busy2 !== 1'b1) begin bad++; $display("FAIL l3_w1 got ack=%b busy=%b want 0 1", ack2, busy2); end
      step(); // cycle 3
      total++; if (ack2 !== 4'b0) begin bad++; $display("FAIL l3_w2 got ack=%b want 0", ack2); end
      step(); // cycle 4: only cycle with the real data
      mrd2 = 32'hCAFEF00D;
      total++; if (ack2 !== 4'b0 || busy2 !== 1'b1) begin bad++; $display("FAIL l3_w3 got ack=%b busy=%b want 0 1", ack2, busy2); end
      step(); // cycle 5
      mrd2 = 32'h0BAD0002;
      total++; if (ack2 !== 4'b0010) begin bad++; $display("FAIL l3_ack got %b want 0010", ack2); end
      total++; if (rdata2 !== 32'hCAFEF00D) begin bad++; $display("FAIL l3_data got %h want cafef00d", rdata2); end
      req2 = 4'b0;
      step();
      total++; if (ack2 !== 4'b0 || busy2 !== 1'b0 || grant2 !== 4'b0 || rdata2 !== 32'hCAFEF00D) begin bad++; $display("FAIL l3_done got ack=%b busy=%b grant=%b rdata=%h want 0 0 0 cafef00d", ack2, busy2, grant2, rdata2); end
   endtask

   task automatic test_reset_mid();
      int w;
      req = 4'b0010; we = 4'b0000; addr[1] = 8'h10;
      step(); // ISSUE
      step(); // WAIT
      total++; if (busy !== 1'b1 || grant !== 4'b0010) begin bad++; $display("FAIL rm_wait got busy=%b grant=%b want 1 0010", busy, grant); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      req = 4'b0;
      total++; if ({ack, grant, busy, mem_en, mem_we} !== 11'b0 || rdata !== 32'h0) begin bad++; $display("FAIL rm_clear got ack=%b grant=%b busy=%b en=%b rdata=%h want 0", ack, grant, busy, mem_en, rdata); end
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_noack i=%0d got ack=%b busy=%b want 0 0", i, ack, busy); end
      end
      req = 4'b1111; we = 4'b1111;
      w = 0;
      do begin
         step();
         w++;
      end while (ack === 4'b0 && w < 8);
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL rm_ptr got ack=%b want 0001", ack); end
      req = 4'b0;
      step();
      step();
   endtask

   task automatic test_drop();
      req = 4'b0010; we = 4'b0000; addr[1] = 8'h20;
      step(); // ISSUE
      step(); // WAIT
      req = 4'b0;
      total++; if (busy !== 1'b1 || grant !== 4'b0010) begin bad++; $display("FAIL dr_wait got busy=%b grant=%b want 1 0010", busy, grant); end
      step(); // ACK
      total++; if (ack !== 4'b0010 || rdata !== 32'h12345678) begin bad++; $display("FAIL dr_ack got ack=%b rdata=%h want 0010 12345678", ack, rdata); end
      step(); // IDLE
      total++; if (busy !== 1'b0 || ack !== 4'b0 || grant !== 4'b0) begin bad++; $display("FAIL dr_idle got busy=%b ack=%b grant=%b want 0", busy, ack, grant); end
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1;
      req = '0; we = '0; addr = '0; wdata = '0;
      req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0; mrd2 = '0;
      test_reset();
      test_write();
      test_read_hold();
      test_round_robin();
      test_latency3();
      test_reset_mid();
      test_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
